// File: rtl/packet_source.sv
`timescale 1ns/1ps
// packet_source: Avalon-ST packet transmitter. On a start request it reads a
// packet word by word from a 32-bit memory with a fixed 1-cycle read latency,
// buffers the returned words in a 2-entry FIFO and streams them out with
// sop/eop/empty/error qualifiers under sink backpressure.
module packet_source (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] byte_len,
    input  logic [5:0]  inject_error,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        ready,
    output logic [31:0] data_out,
    output logic        valid,
    output logic        sop,
    output logic        eop,
    output logic [1:0]  empty,
    output logic [5:0]  error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    // Control state
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;       // address of the next read
    logic [14:0] words_q, words_d;     // packet length in words
    logic [14:0] left_q, left_d;       // reads still to be issued
    logic [14:0] beat_q, beat_d;       // index of the beat at the FIFO head
    logic [1:0]  empty_q, empty_d;     // unused bytes in the last word
    logic [5:0]  err_q, err_d;         // error code for the eop beat
    logic        pend_q;               // a read was issued last cycle

    // Output buffer
    logic [31:0] fifo_mem [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;

    logic [16:0] len_plus3;
    logic [14:0] start_words;
    logic        push, pop, rd_issue, last_beat;
    logic [2:0]  occupancy;

    // Word count rounds the byte length up to whole words.
    assign len_plus3   = {1'b0, byte_len} + 17'd3;
    assign start_words = len_plus3[16:2];

    // The read issued last cycle returns now and is written to the FIFO.
    assign push      = pend_q;
    assign valid     = (count_q != 2'd0);
    assign pop       = valid && ready;
    assign last_beat = (beat_q == words_q - 15'd1);

    // Words buffered or in flight once this cycle's pop is taken into account;
    // a beat leaving this cycle frees its slot for a read in the same cycle.
    assign occupancy = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
    assign rd_issue  = (state_q == S_FETCH) && (left_q != 15'd0) && (occupancy < 3'd2);

    // Next-state logic for the packet FSM and its per-packet registers.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
        left_d  = left_q;
        empty_d = empty_q;
        err_d   = err_q;
        beat_d  = pop ? beat_q + 15'd1 : beat_q;

        case (state_q)
            S_IDLE: begin
                if (start && (byte_len != 16'd0)) begin
                    state_d = S_FETCH;
                    addr_d  = base_addr;
                    words_d = start_words;
                    left_d  = start_words;
                    beat_d  = 15'd0;
                    empty_d = 2'd0 - byte_len[1:0];
                    err_d   = inject_error;
                end
            end
            S_FETCH: begin
                if (rd_issue) begin
                    addr_d = addr_q + 32'd4;
                    left_d = left_q - 15'd1;
                    if (left_q == 15'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO occupancy: a simultaneous write and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State, per-packet and FIFO-control registers.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: non-blocking assignments make every register update from pre-edge values, independent of statement order.
        if (!n_rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            words_q  <= '0;
            left_q   <= '0;
            beat_q   <= '0;
            empty_q  <= '0;
            err_q    <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            words_q <= words_d;
            left_q  <= left_d;
            beat_q  <= beat_d;
            empty_q <= empty_d;
            err_q   <= err_d;
            pend_q  <= rd_issue;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // FIFO storage captures returned read data.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the reset count marks it empty and data_out is gated by valid.
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_rdata;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign mem_read = rd_issue;
    assign mem_addr = addr_q;
    assign data_out = valid ? fifo_mem[rd_ptr_q] : 32'd0;
    assign sop      = valid && (beat_q == 15'd0);
    assign eop      = valid && last_beat;
    assign empty    = eop ? empty_q : 2'd0;
    assign error    = eop ? err_q : 6'd0;

endmodule

// File: tb/tb_packet_source.sv
`timescale 1ns/1ps
// Self-checking bench for packet_source: a memory model answers reads one
// cycle later, a monitor records reads, beats and timing, and each test task
// compares the recording against a packet model built from the packet rules.
module tb_packet_source;

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic [5:0]  error;
    } beat_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] byte_len = '0;
    logic [5:0]  inject_error = '0;
    logic        busy, done, mem_read, valid, sop, eop;
    logic [31:0] mem_addr, data_out;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        ready = 1'b1;
    logic [1:0]  empty;
    logic [5:0]  error;

    int errors = 0;
    int checks = 0;

    packet_source dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .base_addr    (base_addr),
        .byte_len     (byte_len),
        .inject_error (inject_error),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_rdata    (mem_rdata),
        .ready        (ready),
        .data_out     (data_out),
        .valid        (valid),
        .sop          (sop),
        .eop          (eop),
        .empty        (empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed, address-unique pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    // Memory model: data valid exactly one cycle after the read strobe.
    always @(posedge clk) mem_rdata <= mem_read ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    // ---------------- monitor ----------------
    beat_t       beat_q[$];
    logic [31:0] rd_q[$];
    beat_t       exp_q[$];
    logic [31:0] exp_rd[$];
    int ncyc = 0;
    int t_start, t_read0, t_valid0, t_eop, t_done;
    int done_cnt, mon_iss, mon_pop, stab_viol, occ_viol, stall_reads;
    bit    hold = 1'b0;
    beat_t held;

    task automatic clear_mon();
        beat_q.delete();
        rd_q.delete();
        t_start = -1; t_read0 = -1; t_valid0 = -1; t_eop = -1; t_done = -1;
        done_cnt = 0; mon_iss = 0; mon_pop = 0;
        stab_viol = 0; occ_viol = 0; stall_reads = 0;
        hold = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t cur;
        int    occ_after;
        ncyc++;
        cur = {data_out, sop, eop, empty, error};
        if (hold && (cur !== held)) stab_viol++;
        hold = valid && !ready;
        held = cur;
        occ_after = mon_iss - mon_pop + int'(mem_read) - int'(valid && ready);
        if (occ_after > 2) occ_viol++;
        if (start && !busy && (byte_len != 16'd0) && t_start < 0) t_start = ncyc;
        if (mem_read) begin
            rd_q.push_back(mem_addr);
            mon_iss++;
            if (t_read0 < 0) t_read0 = ncyc;
            if (!ready && busy) stall_reads++;
        end
        if (valid && t_valid0 < 0) t_valid0 = ncyc;
        if (valid && ready) begin
            beat_q.push_back(cur);
            mon_pop++;
            if (eop) t_eop = ncyc;
        end
        if (done) begin
            done_cnt++;
            if (t_done < 0) t_done = ncyc;
        end
    end

    // ---------------- reference model ----------------
    task automatic build_model(input logic [31:0] base, input logic [15:0] len, input logic [5:0] err);
        int w;
        beat_t b;
        w = (int'(len) + 3) / 4;
        exp_q.delete();
        exp_rd.delete();
        for (int i = 0; i < w; i++) begin
            exp_rd.push_back(base + 32'(4 * i));
            b.data  = mem_word(base + 32'(4 * i));
            b.sop   = (i == 0);
            b.eop   = (i == w - 1);
            b.empty = b.eop ? 2'((4 - (int'(len) % 4)) % 4) : 2'd0;
            b.error = b.eop ? err : 6'd0;
            exp_q.push_back(b);
        end
    endtask

    // Sends one packet. mode 0: ready high; 1: random ready; 2: six-cycle
    // stall after beat 2. poke pulses a second start while busy.
    task automatic send(input logic [31:0] base, input logic [15:0] len, input logic [5:0] err,
                        input int mode, input bit poke, output bit to);
        int  stall_left = 0;
        bit  stalled = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        base_addr = base; byte_len = len; inject_error = err; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = $urandom; byte_len = 16'($urandom); inject_error = 6'($urandom);
        to = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (poke && c == 2) begin
                start = 1'b1; base_addr = 32'h0000_9000; byte_len = 16'd20; inject_error = 6'h11;
            end else begin
                start = 1'b0;
            end
            if (mode == 1) begin
                ready = ($urandom_range(0, 2) != 0);
            end else if (mode == 2) begin
                if (stall_left > 0) begin
                    ready = 1'b0; stall_left--;
                end else if (!stalled && beat_q.size() >= 3) begin
                    stalled = 1'b1; ready = 1'b0; stall_left = 5;
                end else begin
                    ready = 1'b1;
                end
            end else begin
                ready = 1'b1;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [79:0] outs;
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {busy, done, mem_read, valid, sop, eop, empty, error, mem_addr, data_out};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
        n_rst = 1'b1;
        @(posedge clk); #1;
        outs = {busy, done, mem_read, valid, sop, eop, empty, error, mem_addr, data_out};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_outputs: got %h want 0", outs); end
    endtask

    task automatic test_directed();
        logic [31:0] bases[3] = '{32'h0000_0100, 32'h0000_2000, 32'h0000_003C};
        logic [15:0] lens[3]  = '{16'd8, 16'd5, 16'd1};
        logic [5:0]  errs[3]  = '{6'h00, 6'h00, 6'h2A};
        bit to;
        int w;
        for (int t = 0; t < 3; t++) begin
            build_model(bases[t], lens[t], errs[t]);
            w = exp_q.size();
            send(bases[t], lens[t], errs[t], 0, 1'b0, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_done_timeout: got none want done", t); end
            checks++;
            if (beat_q.size() !== w) begin errors++; $display("FAIL dir%0d_beat_count: got %0d want %0d", t, beat_q.size(), w); end
            for (int i = 0; i < w && i < beat_q.size(); i++) begin
                checks++;
                if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL dir%0d_beat%0d: got %h want %h", t, i, beat_q[i], exp_q[i]); end
            end
            checks++;
            if (rd_q.size() !== w) begin errors++; $display("FAIL dir%0d_read_count: got %0d want %0d", t, rd_q.size(), w); end
            for (int i = 0; i < w && i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== exp_rd[i]) begin errors++; $display("FAIL dir%0d_read%0d: got %h want %h", t, i, rd_q[i], exp_rd[i]); end
            end
            checks++;
            if (t_read0 - t_start !== 1) begin errors++; $display("FAIL dir%0d_read_latency: got %0d want 1", t, t_read0 - t_start); end
            checks++;
            if (t_valid0 - t_start !== 3) begin errors++; $display("FAIL dir%0d_valid_latency: got %0d want 3", t, t_valid0 - t_start); end
            checks++;
            if (t_done - t_start !== w + 3) begin errors++; $display("FAIL dir%0d_done_latency: got %0d want %0d", t, t_done - t_start, w + 3); end
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL dir%0d_done_pulses: got %0d want 1", t, done_cnt); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_after_done: got %b want 0", t, busy); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        logic [5:0]  err;
        bit to;
        base = $urandom & 32'hFFFF_FFFC;
        err  = 6'($urandom);
        build_model(base, 16'd32, err);
        send(base, 16'd32, err, 2, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL bp_done_timeout: got none want done"); end
        checks++;
        if (beat_q.size() !== 8) begin errors++; $display("FAIL bp_beat_count: got %0d want 8", beat_q.size()); end
        for (int i = 0; i < 8 && i < beat_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
        checks++;
        if (rd_q.size() !== 8) begin errors++; $display("FAIL bp_read_count: got %0d want 8", rd_q.size()); end
        for (int i = 0; i < 8 && i < rd_q.size(); i++) begin
            checks++;
            if (rd_q[i] !== exp_rd[i]) begin errors++; $display("FAIL bp_read%0d: got %h want %h", i, rd_q[i], exp_rd[i]); end
        end
        checks++;
        if (stab_viol !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes want 0", stab_viol); end
        checks++;
        if (occ_viol !== 0) begin errors++; $display("FAIL bp_outstanding: got %0d overruns want 0", occ_viol); end
        checks++;
        if (stall_reads !== 0) begin errors++; $display("FAIL bp_reads_in_stall: got %0d want 0", stall_reads); end
        checks++;
        if (t_done - t_eop !== 1) begin errors++; $display("FAIL bp_done_after_eop: got %0d want 1", t_done - t_eop); end
    endtask

    task automatic test_random();
        logic [31:0] base;
        logic [15:0] len;
        logic [5:0]  err;
        bit to;
        for (int p = 0; p < 25; p++) begin
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            len  = 16'($urandom_range(1, 48));
            err  = 6'($urandom);
            build_model(base, len, err);
            send(base, len, err, 1, 1'b0, to);
            checks++;
            if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_timeout: got none want done", p); end
            checks++;
            if (beat_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_beat_count: got %0d want %0d", p, beat_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < beat_q.size(); i++) begin
                checks++;
                if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_beat%0d: got %h want %h", p, i, beat_q[i], exp_q[i]); end
            end
            checks++;
            if (rd_q.size() !== exp_rd.size()) begin errors++; $display("FAIL rnd%0d_read_count: got %0d want %0d", p, rd_q.size(), exp_rd.size()); end
            for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== exp_rd[i]) begin errors++; $display("FAIL rnd%0d_read%0d: got %h want %h", p, i, rd_q[i], exp_rd[i]); end
            end
            checks++;
            if (stab_viol !== 0 || occ_viol !== 0) begin errors++; $display("FAIL rnd%0d_flow: got hold=%0d occ=%0d want 0", p, stab_viol, occ_viol); end
            checks++;
            if (t_done - t_eop !== 1 || done_cnt !== 1) begin errors++; $display("FAIL rnd%0d_done: got gap=%0d pulses=%0d want 1", p, t_done - t_eop, done_cnt); end
        end
    endtask

    task automatic test_ignored();
        bit to;
        @(posedge clk); #1;
        clear_mon();
        base_addr = 32'h0000_5000; byte_len = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rd_q.size() !== 0 || beat_q.size() !== 0 || done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_ignored: got reads=%0d beats=%0d done=%0d busy=%b want 0", rd_q.size(), beat_q.size(), done_cnt, busy);
        end
        build_model(32'h0000_4000, 16'd12, 6'h05);
        send(32'h0000_4000, 16'd12, 6'h05, 0, 1'b1, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: got none want done"); end
        checks++;
        if (beat_q.size() !== 3) begin errors++; $display("FAIL busy_start_beats: got %0d want 3", beat_q.size()); end
        for (int i = 0; i < 3 && i < beat_q.size(); i++) begin
            checks++;
            if (beat_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_start_beat%0d: got %h want %h", i, beat_q[i], exp_q[i]); end
        end
        checks++;
        if (rd_q.size() !== 3) begin errors++; $display("FAIL busy_start_reads: got %0d want 3", rd_q.size()); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_after: got done=%0d busy=%b want 1,0", done_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        logic [79:0] outs;
        bit to;
        bit reached = 1'b0;
        @(posedge clk); #1;
        clear_mon();
        base_addr = 32'h0000_7000; byte_len = 16'd32; inject_error = 6'h3F; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (beat_q.size() >= 2) begin reached = 1'b1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL mid_reach_beat1: got %0d beats want 2", beat_q.size()); end
        n_rst = 1'b0;
        #1;
        outs = {busy, done, mem_read, valid, sop, eop, empty, error, mem_addr, data_out};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
        #2;
        n_rst = 1'b1;
        @(posedge clk); #1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (beat_q.size() !== 0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale_data: got beats=%0d valid=%b busy=%b want 0", beat_q.size(), valid, busy);
        end
        build_model(32'h0000_0800, 16'd4, 6'h00);
        send(32'h0000_0800, 16'd4, 6'h00, 0, 1'b0, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL mid_next_timeout: got none want done"); end
        checks++;
        if (beat_q.size() !== 1) begin errors++; $display("FAIL mid_next_beats: got %0d want 1", beat_q.size()); end
        else begin
            checks++;
            if (beat_q[0] !== exp_q[0]) begin errors++; $display("FAIL mid_next_beat0: got %h want %h", beat_q[0], exp_q[0]); end
        end
        checks++;
        if (rd_q.size() !== 1 || (rd_q.size() == 1 && rd_q[0] !== 32'h0000_0800)) begin
            errors++;
            $display("FAIL mid_next_reads: got %0d reads want 1 at 00000800", rd_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_mon();
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
